// File: rtl/time_cnt_if.sv
// Stopwatch time-base bus: run/clear controls in, BCD digits and status out.
// The lap input exists only when TIME_CNT_LAP_EN is defined.
interface time_cnt_if;
    logic       time_en;
    logic       clr;
`ifdef TIME_CNT_LAP_EN
    logic       lap;
`endif
    logic [3:0] cs_l;
    logic [3:0] cs_h;
    logic [3:0] sec_l;
    logic [3:0] sec_h;
    logic [3:0] min_l;
    logic [3:0] min_h;
    logic       wrap;
    logic       hold;

    modport master (
`ifdef TIME_CNT_LAP_EN
        output lap,
`endif
        output time_en, clr,
        input  cs_l, cs_h, sec_l, sec_h, min_l, min_h, wrap, hold
    );

    modport slave (
`ifdef TIME_CNT_LAP_EN
        input  lap,
`endif
        input  time_en, clr,
        output cs_l, cs_h, sec_l, sec_h, min_l, min_h, wrap, hold
    );
endinterface

// File: rtl/time_cnt.sv
// Stopwatch time base: prescaler plus MM:SS.cc BCD cascade.
// Define TIME_CNT_LAP_EN to add the lap-hold snapshot display.
module time_cnt #(
    parameter int CLK_DIV = 10
) (
    input logic       clk,
    input logic       rst,
    time_cnt_if.slave bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_n;
    logic          tick;

    logic [3:0] live_cs_l, live_cs_h, live_sec_l;
    logic [3:0] live_sec_h, live_min_l, live_min_h;
    logic [3:0] cur_cs_l, cur_cs_h, cur_sec_l;
    logic [3:0] cur_sec_h, cur_min_l, cur_min_h;
    logic [3:0] nxt_cs_l, nxt_cs_h, nxt_sec_l;
    logic [3:0] nxt_sec_h, nxt_min_l, nxt_min_h;
    logic       c_cs_l, c_cs_h, c_sec_l, c_sec_h, c_min_l;
    logic       wrap_r;
    logic       wrap_n;

    function automatic logic [3:0] fix(input logic [3:0] d,
                                       input logic [3:0] max);
        return (d > max) ? 4'd0 : d;
    endfunction

    function automatic logic [3:0] bump(input logic [3:0] d,
                                        input logic [3:0] max,
                                        input logic       en);
        if (!en)
            return d;
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

    // >= rather than == so a corrupted prescaler still recovers
    assign tick = bus.time_en && (pre >= PRE_LAST);

    always_comb begin
        pre_n = pre;
        if (bus.clr)
            pre_n = '0;
        else if (tick)
            pre_n = '0;
        else if (bus.time_en)
            pre_n = pre + 1'b1;
    end

    always_comb begin
        cur_cs_l  = fix(live_cs_l, 4'd9);
        cur_cs_h  = fix(live_cs_h, 4'd9);
        cur_sec_l = fix(live_sec_l, 4'd9);
        cur_sec_h = fix(live_sec_h, 4'd5);
        cur_min_l = fix(live_min_l, 4'd9);
        cur_min_h = fix(live_min_h, 4'd5);

        c_cs_l  = tick && (cur_cs_l == 4'd9);
        c_cs_h  = c_cs_l && (cur_cs_h == 4'd9);
        c_sec_l = c_cs_h && (cur_sec_l == 4'd9);
        c_sec_h = c_sec_l && (cur_sec_h == 4'd5);
        c_min_l = c_sec_h && (cur_min_l == 4'd9);
        wrap_n  = c_min_l && (cur_min_h == 4'd5);

        nxt_cs_l  = bump(cur_cs_l, 4'd9, tick);
        nxt_cs_h  = bump(cur_cs_h, 4'd9, c_cs_l);
        nxt_sec_l = bump(cur_sec_l, 4'd9, c_cs_h);
        nxt_sec_h = bump(cur_sec_h, 4'd5, c_sec_l);
        nxt_min_l = bump(cur_min_l, 4'd9, c_sec_h);
        nxt_min_h = bump(cur_min_h, 4'd5, c_min_l);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre        <= '0;
            live_cs_l  <= 4'd0;
            live_cs_h  <= 4'd0;
            live_sec_l <= 4'd0;
            live_sec_h <= 4'd0;
            live_min_l <= 4'd0;
            live_min_h <= 4'd0;
            wrap_r     <= 1'b0;
        end else if (bus.clr) begin
            pre        <= '0;
            live_cs_l  <= 4'd0;
            live_cs_h  <= 4'd0;
            live_sec_l <= 4'd0;
            live_sec_h <= 4'd0;
            live_min_l <= 4'd0;
            live_min_h <= 4'd0;
            wrap_r     <= 1'b0;
        end else begin
            pre        <= pre_n;
            live_cs_l  <= nxt_cs_l;
            live_cs_h  <= nxt_cs_h;
            live_sec_l <= nxt_sec_l;
            live_sec_h <= nxt_sec_h;
            live_min_l <= nxt_min_l;
            live_min_h <= nxt_min_h;
            wrap_r     <= wrap_n;
        end
    end

    assign bus.wrap = wrap_r;

`ifdef TIME_CNT_LAP_EN
    logic        hold_r;
    logic        hold_n;
    logic [23:0] snap;
    logic [23:0] snap_n;
    logic [23:0] disp;
    logic [23:0] disp_n;
    logic [23:0] cur_vec;
    logic [23:0] nxt_vec;

    assign cur_vec = {cur_min_h, cur_min_l, cur_sec_h,
                      cur_sec_l, cur_cs_h, cur_cs_l};
    assign nxt_vec = {nxt_min_h, nxt_min_l, nxt_sec_h,
                      nxt_sec_l, nxt_cs_h, nxt_cs_l};

    // Snapshot takes the pre-tick digits; display is registered
    always_comb begin
        hold_n = hold_r;
        snap_n = snap;
        if (bus.lap) begin
            if (hold_r) begin
                hold_n = 1'b0;
            end else begin
                hold_n = 1'b1;
                snap_n = cur_vec;
            end
        end
        disp_n = hold_n ? snap_n : nxt_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= 1'b0;
            snap   <= 24'd0;
            disp   <= 24'd0;
        end else if (bus.clr) begin
            hold_r <= 1'b0;
            snap   <= 24'd0;
            disp   <= 24'd0;
        end else begin
            hold_r <= hold_n;
            snap   <= snap_n;
            disp   <= disp_n;
        end
    end

    assign bus.cs_l  = disp[3:0];
    assign bus.cs_h  = disp[7:4];
    assign bus.sec_l = disp[11:8];
    assign bus.sec_h = disp[15:12];
    assign bus.min_l = disp[19:16];
    assign bus.min_h = disp[23:20];
    assign bus.hold  = hold_r;
`else
    assign bus.cs_l  = live_cs_l;
    assign bus.cs_h  = live_cs_h;
    assign bus.sec_l = live_sec_l;
    assign bus.sec_h = live_sec_h;
    assign bus.min_l = live_min_l;
    assign bus.min_h = live_min_h;
    assign bus.hold  = 1'b0;
`endif
endmodule

// File: tb/tb_time_cnt.sv
// Directed bench for time_cnt: CLK_DIV=10 and CLK_DIV=1 instances.
// Lap-hold steps run only when TIME_CNT_LAP_EN is defined.
module tb_time_cnt;
    logic clk = 1'b0;
    logic rst10;
    logic rst1;
    int   vectors = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    time_cnt_if if10 ();
    time_cnt_if if1 ();

    time_cnt #(.CLK_DIV(10)) u10 (.clk(clk), .rst(rst10), .bus(if10));
    time_cnt #(.CLK_DIV(1))  u1  (.clk(clk), .rst(rst1),  .bus(if1));

    function automatic logic [23:0] vec10();
        return {if10.min_h, if10.min_l, if10.sec_h,
                if10.sec_l, if10.cs_h, if10.cs_l};
    endfunction

    function automatic logic [23:0] vec1();
        return {if1.min_h, if1.min_l, if1.sec_h,
                if1.sec_l, if1.cs_h, if1.cs_l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then park on the falling edge
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    initial begin
        rst10 = 1'b1;
        rst1  = 1'b1;
        if10.time_en = 1'b0;
        if10.clr     = 1'b0;
        if1.time_en  = 1'b0;
        if1.clr      = 1'b0;
`ifdef TIME_CNT_LAP_EN
        if10.lap = 1'b0;
        if1.lap  = 1'b0;
`endif
        @(negedge clk);
        chk("rst_digits10", {8'd0, vec10()}, 32'h0);
        chk("rst_wrap10", {31'd0, if10.wrap}, 32'd0);
        chk("rst_hold10", {31'd0, if10.hold}, 32'd0);
        chk("rst_digits1", {8'd0, vec1()}, 32'h0);
        rst10 = 1'b0;
        rst1  = 1'b0;

        // prescaler keeps a partial centisecond across stop/start
        if10.time_en = 1'b1;
        edges(25);
        chk("run25_digits", {8'd0, vec10()}, 32'h000002);
        chk("run25_pre", 32'(u10.pre), 32'd5);
        if10.time_en = 1'b0;
        edges(50);
        chk("stop50_digits", {8'd0, vec10()}, 32'h000002);
        chk("stop50_pre", 32'(u10.pre), 32'd5);
        if10.time_en = 1'b1;
        edges(4);
        chk("pre_tick_digits", {8'd0, vec10()}, 32'h000002);
        edges(1);
        chk("resume_digits", {8'd0, vec10()}, 32'h000003);
        chk("resume_pre", 32'(u10.pre), 32'd0);
        if10.time_en = 1'b0;

        // CLK_DIV=1: one tick per enabled edge
        if1.time_en = 1'b1;
        edges(100);
        chk("one_second", {8'd0, vec1()}, 32'h000100);
        edges(5900);
        chk("one_minute", {8'd0, vec1()}, 32'h010000);
        if1.time_en = 1'b0;

        // clear wins over a simultaneous enable
        reset1();
        if1.time_en = 1'b1;
        edges(37);
        chk("pre_clr", {8'd0, vec1()}, 32'h000037);
        if1.clr = 1'b1;
        edges(1);
        chk("clr_digits", {8'd0, vec1()}, 32'h000000);
        if1.clr = 1'b0;
        edges(1);
        chk("after_clr", {8'd0, vec1()}, 32'h000001);
        if1.time_en = 1'b0;

        // asynchronous reset between edges
        reset1();
        if1.time_en = 1'b1;
        edges(1234);
        chk("pre_async", {8'd0, vec1()}, 32'h001234);
        if1.time_en = 1'b0;
        #2;
        rst1 = 1'b1;
        #1;
        chk("async_digits", {8'd0, vec1()}, 32'h0);
        chk("async_wrap", {31'd0, if1.wrap}, 32'd0);
        @(negedge clk);
        rst1 = 1'b0;

        // preload 59:59.90 with counting stopped, then roll over
        force u1.live_cs_l  = 4'd0;
        force u1.live_cs_h  = 4'd9;
        force u1.live_sec_l = 4'd9;
        force u1.live_sec_h = 4'd5;
        force u1.live_min_l = 4'd9;
        force u1.live_min_h = 4'd5;
        edges(1);
        release u1.live_cs_l;
        release u1.live_cs_h;
        release u1.live_sec_l;
        release u1.live_sec_h;
        release u1.live_min_l;
        release u1.live_min_h;
        edges(1);
        chk("preload", {8'd0, vec1()}, 32'h595990);
        if1.time_en = 1'b1;
        edges(9);
        chk("max_digits", {8'd0, vec1()}, 32'h595999);
        chk("max_wrap", {31'd0, if1.wrap}, 32'd0);
        edges(1);
        chk("wrap_digits", {8'd0, vec1()}, 32'h000000);
        chk("wrap_pulse", {31'd0, if1.wrap}, 32'd1);
        edges(1);
        chk("post_wrap_digits", {8'd0, vec1()}, 32'h000001);
        chk("post_wrap_pulse", {31'd0, if1.wrap}, 32'd0);
        if1.time_en = 1'b0;

        // out-of-range digit is scrubbed on the next edge
        force u1.live_sec_h = 4'd7;
        edges(1);
        release u1.live_sec_h;
        edges(1);
        chk("seu_scrub", {8'd0, vec1()}, 32'h000001);

`ifdef TIME_CNT_LAP_EN
        reset1();
        if1.time_en = 1'b1;
        edges(50);
        chk("lap_pre", {8'd0, vec1()}, 32'h000050);
        if1.lap = 1'b1;
        edges(1);
        if1.lap = 1'b0;
        chk("lap_freeze", {8'd0, vec1()}, 32'h000050);
        chk("lap_hold_set", {31'd0, if1.hold}, 32'd1);
        edges(49);
        chk("lap_still", {8'd0, vec1()}, 32'h000050);
        if1.lap = 1'b1;
        edges(1);
        if1.lap = 1'b0;
        chk("lap_release", {8'd0, vec1()}, 32'h000101);
        chk("lap_hold_clr", {31'd0, if1.hold}, 32'd0);
        if1.time_en = 1'b0;
`else
        chk("hold_tied", {31'd0, if1.hold}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end
endmodule
